// File: rtl/ch_eqlz_zf.sv
// -----------------------------------------------------------------------------
// ch_eqlz_zf -- zero-forcing equalizer stage
//
// Sits directly behind the channel estimator. The two interpolated channel
// estimates (h1, h2) are latched on each valid_eqlz pulse. Data REs are then
// accepted one at a time and divided by the selected estimate:
//
//     eq = rx / h = rx * conj(h) / |h|^2
//
// The result is signed fixed point. h uses H_FRAC fractional bits, so
// h = 2^H_FRAC means unity gain. The I and Q quotients come from one
// restoring divider schedule that runs both paths in lock step, one quotient
// bit per cycle, MSB first.
//
// Optional build macro:
//   CH_EQLZ_ROUND_EN - The divider produces one extra guard bit. The result
//                      is rounded half away from zero instead of truncated
//                      toward zero. Latency and throughput grow by one cycle.
//
// Ports:
//   clk                      clock
//   rst                      asynchronous active-low reset
//   h_eqlz_1_r / h_eqlz_1_i  estimate 1 (signed, WIDTH_H)
//   h_eqlz_2_r / h_eqlz_2_i  estimate 2 (signed, WIDTH_H)
//   valid_eqlz               single-cycle pulse, estimates valid
//   rx_r / rx_i              data RE (signed, WIDTH_RX)
//   rx_valid                 data RE offered
//   h_sel                    0: estimate 1, 1: estimate 2 (sampled with rx)
//   eq_ready                 block can accept a data RE
//   eq_r / eq_i              equalized RE (signed, OUT_WIDTH)
//   eq_valid                 single-cycle pulse, eq_r / eq_i valid
//   div_zero                 qualifies eq_valid: selected |h|^2 was zero
//   sat                      qualifies eq_valid: a component saturated
// -----------------------------------------------------------------------------
module ch_eqlz_zf #(
  parameter int WIDTH_H   = 17,
  parameter int WIDTH_RX  = 16,
  parameter int OUT_WIDTH = 16,
  parameter int H_FRAC    = 12
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH_H-1:0]   h_eqlz_1_r,
  input  logic [WIDTH_H-1:0]   h_eqlz_1_i,
  input  logic [WIDTH_H-1:0]   h_eqlz_2_r,
  input  logic [WIDTH_H-1:0]   h_eqlz_2_i,
  input  logic                 valid_eqlz,
  input  logic [WIDTH_RX-1:0]  rx_r,
  input  logic [WIDTH_RX-1:0]  rx_i,
  input  logic                 rx_valid,
  input  logic                 h_sel,
  output logic                 eq_ready,
  output logic [OUT_WIDTH-1:0] eq_r,
  output logic [OUT_WIDTH-1:0] eq_i,
  output logic                 eq_valid,
  output logic                 div_zero,
  output logic                 sat
);

`ifdef CH_EQLZ_ROUND_EN
  localparam int RND = 1;
`else
  localparam int RND = 0;
`endif

  // Full-precision numerator (signed) and denominator (unsigned) widths.
  localparam int NUM_W = WIDTH_RX + WIDTH_H + 1;
  localparam int DEN_W = 2 * WIDTH_H;
  // Quotient bits, including the rounding guard bit when it is enabled.
  localparam int QBITS = OUT_WIDTH - 1 + RND;
  // Dividend width, which is |num| shifted left by H_FRAC (+1 with guard bit).
  localparam int DW    = NUM_W + H_FRAC + RND;
  // Working width of the remainder and divisor. It holds den << QBITS.
  localparam int CW    = ((DW > DEN_W + QBITS) ? DW : (DEN_W + QBITS)) + 1;
  localparam int CNT_W = $clog2(QBITS) + 1;

  localparam logic [OUT_WIDTH-1:0] MAX_POS = {1'b0, {(OUT_WIDTH-1){1'b1}}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MULT = 2'd1,
    ST_DIV  = 2'd2,
    ST_OUT  = 2'd3
  } state_t;

  state_t               state_r;

  // Stored estimates
  logic [WIDTH_H-1:0]   h1_re_r, h1_im_r, h2_re_r, h2_im_r;
  logic                 h_loaded_r;

  // Operands captured at accept
  logic [WIDTH_RX-1:0]  op_rx_re_r, op_rx_im_r;
  logic [WIDTH_H-1:0]   op_h_re_r, op_h_im_r;

  // Products registered in MULT
  logic                 neg_re_r, neg_im_r;
  logic [NUM_W-1:0]     mag_re_r, mag_im_r;
  logic [DEN_W-1:0]     den_r;

  // Divider state
  logic [CW-1:0]        rem_re_r, rem_im_r, dsr_r;
  logic [QBITS-1:0]     quo_re_r, quo_im_r;
  logic [CNT_W-1:0]     cnt_r;
  logic                 sat_re_r, sat_im_r;

  // Combinational helpers
  logic signed [NUM_W-1:0] rx_re_x_s, rx_im_x_s, h_re_x_s, h_im_x_s;
  logic signed [NUM_W-1:0] num_re_s, num_im_s;
  logic signed [DEN_W-1:0] h_re_d_s, h_im_d_s;
  logic [DEN_W-1:0]        den_s;
  logic [NUM_W-1:0]        mag_re_s, mag_im_s;
  logic [CW-1:0]           rem_re_cur_s, rem_im_cur_s, dsr_cur_s, den_lim_s;
  logic [CW-1:0]           rem_re_nxt_s, rem_im_nxt_s;
  logic                    ge_re_s, ge_im_s, ovf_re_s, ovf_im_s;
  logic [OUT_WIDTH-1:0]    mag_out_re_s, mag_out_im_s;
  logic                    rovf_re_s, rovf_im_s;

  // Apply the sign to a magnitude. A saturated component is clamped
  // symmetrically and never reaches the most-negative code.
  function automatic logic [OUT_WIDTH-1:0] fmt_out(
    input logic                 neg,
    input logic [OUT_WIDTH-1:0] mag,
    input logic                 ovf
  );
    logic [OUT_WIDTH-1:0] m;
    if (ovf) begin
      m = MAX_POS;
    end else begin
      m = mag;
    end
    if (neg) begin
      fmt_out = -m;
    end else begin
      fmt_out = m;
    end
  endfunction

  assign eq_ready = (state_r == ST_IDLE) && h_loaded_r;

  // Complex multiply by conj(h) and |h|^2. The operands are sign-extended so
  // every product is formed at full precision.
  always_comb begin
    rx_re_x_s = NUM_W'($signed(op_rx_re_r));
    rx_im_x_s = NUM_W'($signed(op_rx_im_r));
    h_re_x_s  = NUM_W'($signed(op_h_re_r));
    h_im_x_s  = NUM_W'($signed(op_h_im_r));
    h_re_d_s  = DEN_W'($signed(op_h_re_r));
    h_im_d_s  = DEN_W'($signed(op_h_im_r));
    num_re_s  = rx_re_x_s * h_re_x_s + rx_im_x_s * h_im_x_s;
    num_im_s  = rx_im_x_s * h_re_x_s - rx_re_x_s * h_im_x_s;
    den_s     = $unsigned(h_re_d_s * h_re_d_s) + $unsigned(h_im_d_s * h_im_d_s);
    if (num_re_s[NUM_W-1]) begin
      mag_re_s = -num_re_s;
    end else begin
      mag_re_s = num_re_s;
    end
    if (num_im_s[NUM_W-1]) begin
      mag_im_s = -num_im_s;
    end else begin
      mag_im_s = num_im_s;
    end
  end

  // One restoring-divide step for each path. On the first DIV cycle the
  // dividend and the top-aligned divisor are loaded from the MULT results.
  always_comb begin
    if (cnt_r == '0) begin
      rem_re_cur_s = CW'(mag_re_r) << (H_FRAC + RND);
      rem_im_cur_s = CW'(mag_im_r) << (H_FRAC + RND);
      dsr_cur_s    = CW'(den_r) << (QBITS - 1);
    end else begin
      rem_re_cur_s = rem_re_r;
      rem_im_cur_s = rem_im_r;
      dsr_cur_s    = dsr_r;
    end
    // The quotient needs more than QBITS bits exactly when the dividend
    // is at least den << QBITS.
    den_lim_s = CW'(den_r) << QBITS;
    ovf_re_s  = (rem_re_cur_s >= den_lim_s);
    ovf_im_s  = (rem_im_cur_s >= den_lim_s);
    ge_re_s   = (rem_re_cur_s >= dsr_cur_s);
    ge_im_s   = (rem_im_cur_s >= dsr_cur_s);
    if (ge_re_s) begin
      rem_re_nxt_s = rem_re_cur_s - dsr_cur_s;
    end else begin
      rem_re_nxt_s = rem_re_cur_s;
    end
    if (ge_im_s) begin
      rem_im_nxt_s = rem_im_cur_s - dsr_cur_s;
    end else begin
      rem_im_nxt_s = rem_im_cur_s;
    end
  end

  // Final magnitude: plain quotient, or quotient plus its guard bit for
  // rounding. Rounding up can reach 2^(OUT_WIDTH-1), which is an overflow.
  always_comb begin
`ifdef CH_EQLZ_ROUND_EN
    mag_out_re_s = OUT_WIDTH'(quo_re_r[QBITS-1:1]) + OUT_WIDTH'(quo_re_r[0]);
    mag_out_im_s = OUT_WIDTH'(quo_im_r[QBITS-1:1]) + OUT_WIDTH'(quo_im_r[0]);
`else
    mag_out_re_s = OUT_WIDTH'(quo_re_r);
    mag_out_im_s = OUT_WIDTH'(quo_im_r);
`endif
    rovf_re_s = mag_out_re_s[OUT_WIDTH-1];
    rovf_im_s = mag_out_im_s[OUT_WIDTH-1];
  end

  // Estimate storage. New estimates can arrive in any state. An in-flight
  // operation is unaffected because it works from its own operand copies.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      h1_re_r    <= '0;
      h1_im_r    <= '0;
      h2_re_r    <= '0;
      h2_im_r    <= '0;
      h_loaded_r <= 1'b0;
    end else if (valid_eqlz) begin
      h1_re_r    <= h_eqlz_1_r;
      h1_im_r    <= h_eqlz_1_i;
      h2_re_r    <= h_eqlz_2_r;
      h2_im_r    <= h_eqlz_2_i;
      h_loaded_r <= 1'b1;
    end
  end

  // Equalizer FSM with registered result outputs. At accept it reads the
  // estimate registers before this edge's update, so an RE accepted together
  // with valid_eqlz uses the previous estimates.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= ST_IDLE;
      op_rx_re_r <= '0;
      op_rx_im_r <= '0;
      op_h_re_r  <= '0;
      op_h_im_r  <= '0;
      neg_re_r   <= 1'b0;
      neg_im_r   <= 1'b0;
      mag_re_r   <= '0;
      mag_im_r   <= '0;
      den_r      <= '0;
      rem_re_r   <= '0;
      rem_im_r   <= '0;
      dsr_r      <= '0;
      quo_re_r   <= '0;
      quo_im_r   <= '0;
      cnt_r      <= '0;
      sat_re_r   <= 1'b0;
      sat_im_r   <= 1'b0;
      eq_r       <= '0;
      eq_i       <= '0;
      eq_valid   <= 1'b0;
      div_zero   <= 1'b0;
      sat        <= 1'b0;
    end else begin
      eq_valid <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (rx_valid && eq_ready) begin
            op_rx_re_r <= rx_r;
            op_rx_im_r <= rx_i;
            op_h_re_r  <= h_sel ? h2_re_r : h1_re_r;
            op_h_im_r  <= h_sel ? h2_im_r : h1_im_r;
            state_r    <= ST_MULT;
          end
        end
        ST_MULT: begin
          neg_re_r <= num_re_s[NUM_W-1];
          neg_im_r <= num_im_s[NUM_W-1];
          mag_re_r <= mag_re_s;
          mag_im_r <= mag_im_s;
          den_r    <= den_s;
          cnt_r    <= '0;
          state_r  <= ST_DIV;
        end
        ST_DIV: begin
          rem_re_r <= rem_re_nxt_s;
          rem_im_r <= rem_im_nxt_s;
          dsr_r    <= dsr_cur_s >> 1;
          quo_re_r <= {quo_re_r[QBITS-2:0], ge_re_s};
          quo_im_r <= {quo_im_r[QBITS-2:0], ge_im_s};
          if (cnt_r == '0) begin
            sat_re_r <= ovf_re_s;
            sat_im_r <= ovf_im_s;
          end
          if (cnt_r == CNT_W'(QBITS - 1)) begin
            state_r <= ST_OUT;
          end
          cnt_r <= cnt_r + CNT_W'(1);
        end
        ST_OUT: begin
          if (den_r == '0) begin
            eq_r     <= '0;
            eq_i     <= '0;
            div_zero <= 1'b1;
            sat      <= 1'b0;
          end else begin
            eq_r     <= fmt_out(neg_re_r, mag_out_re_s, sat_re_r | rovf_re_s);
            eq_i     <= fmt_out(neg_im_r, mag_out_im_s, sat_im_r | rovf_im_s);
            div_zero <= 1'b0;
            sat      <= sat_re_r | rovf_re_s | sat_im_r | rovf_im_s;
          end
          eq_valid <= 1'b1;
          state_r  <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/ch_eqlz_zf.md
Name: ch_eqlz_zf

Overview:
- Zero-forcing equalizer stage directly downstream of the channel estimator.
- Latches the estimator's two interpolated channel estimates (h1, h2) on each valid_eqlz pulse.
- Accepts demapped data REs one at a time and returns rx/h as signed fixed-point I/Q.
- Uses a multi-cycle restoring divider shared by the I and Q paths (same iteration schedule).
- Output goes to the soft demodulator.

Parameters:
WIDTH_H, 17, signed width of each channel-estimate component (matches estimator OUT_WIDTH)
WIDTH_RX, 16, signed width of each data RE component
OUT_WIDTH, 16, signed width of each equalized output component
H_FRAC, 12, fractional bits of h (h = 2^H_FRAC means gain 1.0)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-low reset
h_eqlz_1_r, h_eqlz_1_i  in  WIDTH_H  estimate 1 (signed)
h_eqlz_2_r, h_eqlz_2_i  in  WIDTH_H  estimate 2 (signed)
valid_eqlz  in  1  single-cycle pulse, estimates valid
rx_r, rx_i  in  WIDTH_RX  data RE (signed)
rx_valid  in  1  data RE offered
h_sel  in  1  0: use estimate 1, 1: use estimate 2; sampled with rx
eq_ready  out  1  block can accept a data RE
eq_r, eq_i  out  OUT_WIDTH  equalized RE (signed)
eq_valid  out  1  single-cycle pulse, eq_r/eq_i valid
div_zero  out  1  qualifies eq_valid: selected |h|^2 was 0
sat  out  1  qualifies eq_valid: either component saturated

Behaviour:
- Reset is asynchronous, active-low: clk and rst as in the rest of the codebase. While rst=0, force the following:
  - all outputs 0; eq_ready=0
  - h_loaded=0, FSM=IDLE
- If reset asserts mid-operation, the in-flight result is discarded and no eq_valid is produced.
- Estimate capture: on valid_eqlz=1, register all four h components and set h_loaded=1.
  - valid_eqlz can arrive in any state.
  - An operation already in flight keeps the operands it captured at accept.
- eq_ready = (state==IDLE) && h_loaded.
- A data RE is accepted on a clock edge where rx_valid && eq_ready.
  - On accept, capture rx_r, rx_i and the estimate selected by h_sel into operand registers.
  - If valid_eqlz and accept coincide, the accepted RE uses the previously stored estimates; the new estimates take effect from the next accept.
- FSM states:
  - IDLE: on accept, go to MULT.
  - MULT (1 cycle):
    - num_r = rx_r*h_r + rx_i*h_i
    - num_i = rx_i*h_r - rx_r*h_i
    - den = h_r^2 + h_i^2 (unsigned)
    - full precision: WIDTH_RX+WIDTH_H+1 bits signed; den is 2*WIDTH_H bits.
    - Register the signs and magnitudes of num_r and num_i.
    - Go to DIV.
  - DIV (OUT_WIDTH-1 cycles):
    - Restoring divide of |num|*2^H_FRAC by den, for I and Q in parallel.
    - One quotient bit per cycle, MSB first.
    - Overflow pre-check on the first DIV cycle: if |num|*2^H_FRAC >= den*2^(OUT_WIDTH-1), that component saturates.
    - Then go to OUT.
  - OUT (1 cycle):
    - Apply the sign; result is truncated toward zero.
    - Saturated components drive +(2^(OUT_WIDTH-1)-1) or -(2^(OUT_WIDTH-1)-1), never the most-negative code; set sat=1.
    - If den==0: eq_r=eq_i=0, div_zero=1, sat=0.
    - Pulse eq_valid, then go to IDLE.
- Timing:
  - Latency: eq_valid is high in the cycle after edge T+OUT_WIDTH+1, where T is the accepting edge.
  - Throughput: one RE per OUT_WIDTH+2 cycles.
- eq_r, eq_i, div_zero and sat hold their value until the next OUT.
- rx_valid while eq_ready=0 is ignored; the upstream stage holds data until accepted.

Optional Feature:
- Macro: CH_EQLZ_ROUND_EN.
- Defined:
  - The divider runs one extra iteration (OUT_WIDTH cycles in DIV).
  - The guard bit is added to the magnitude, giving round-half-away-from-zero.
  - Saturation is re-checked after rounding.
  - Latency and throughput grow by 1 cycle.
- Undefined: truncation toward zero and the timing above.

Test Plan:
- Unity channel: valid_eqlz with h1=(4096,0); accept rx=(1000,-500), h_sel=0 -> eq=(1000,-500), sat=0, div_zero=0. eq_valid 17 cycles after accept (18 with round).
- 90-degree rotation: h2=(0,4096); rx=(1000,0), h_sel=1 -> eq=(0,-1000).
- Truncation vs rounding: h1=(12288,0); rx=(-1001,0) -> eq_r=-333 without CH_EQLZ_ROUND_EN, -334 with it. rx=(1000,0) -> 333 in both builds.
- Boundary, zero and saturation:
  - h1=(0,0); rx=(5,5) -> eq=(0,0), div_zero=1.
  - h1=(1,0); rx=(30000,-30000) -> eq=(32767,-32767), sat=1.
- Handshake and reset:
  - Before any valid_eqlz, eq_ready=0 and rx_valid is ignored.
  - valid_eqlz with h1=(8192,0) in the accept cycle of an RE under h1=(4096,0): that RE uses 4096; the next RE uses 8192.
  - rst=0 during DIV -> no eq_valid; after reset release, eq_ready stays 0 until the next valid_eqlz.
